// File: rtl/mips_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_pc_sequencer
// Purpose  : Registered MIPS-I PC unit with branch delay slot, link and halt.
//            Optional PC_BRANCH_STATS_EN adds retired/taken counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int          DELAY_SLOT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        halted,
`ifdef PC_BRANCH_STATS_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] taken_cnt,
`endif
  output logic        fault
);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_DELAY  = 2'd1;
  localparam logic [1:0] c_ST_HALTED = 2'd2;
  localparam bit         c_DS        = (DELAY_SLOT != 0);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_link_we;
  logic [4:0]  r_link_reg;
  logic [31:0] r_link_data;
  logic        r_halted;
  logic        r_fault;

  logic [5:0]  w_op;
  logic [31:0] w_pc4;
  logic [31:0] w_pc8;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_rs_zero;
  logic        w_rs_neg;
  logic        w_taken;
  logic        w_link;
  logic [4:0]  w_link_reg;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_redirect;
  logic [31:0] w_redir_tgt;

  assign w_op      = instr[31:26];
  assign w_pc4     = r_pc + 32'd4;
  assign w_pc8     = r_pc + 32'd8;
  assign w_br_tgt  = w_pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign w_j_tgt   = {w_pc4[31:28], instr[25:0], 2'b00};
  assign w_rs_zero = (rs_val == 32'd0);
  assign w_rs_neg  = rs_val[31];

  always_comb begin
    w_taken    = 1'b0;
    w_link     = 1'b0;
    w_link_reg = 5'd31;
    w_target   = w_br_tgt;
    case (w_op)
      6'b000100: w_taken = (rs_val == rt_val);
      6'b000101: w_taken = (rs_val != rt_val);
      6'b000110: w_taken = w_rs_neg | w_rs_zero;
      6'b000111: w_taken = ~w_rs_neg & ~w_rs_zero;
      6'b000001: begin
        case (instr[20:16])
          5'b00000: w_taken = w_rs_neg;
          5'b00001: w_taken = ~w_rs_neg;
          5'b10000: begin w_taken = w_rs_neg;  w_link = 1'b1; end
          5'b10001: begin w_taken = ~w_rs_neg; w_link = 1'b1; end
          default: ;
        endcase
      end
      6'b000010: begin w_taken = 1'b1; w_target = w_j_tgt; end
      6'b000011: begin w_taken = 1'b1; w_target = w_j_tgt; w_link = 1'b1; end
      6'b000000: begin
        if (instr[5:0] == 6'b001000) begin
          w_taken  = 1'b1;
          w_target = rs_val;
        end else if (instr[5:0] == 6'b001001) begin
          w_taken    = 1'b1;
          w_target   = rs_val;
          w_link     = 1'b1;
          w_link_reg = instr[15:11];
        end
      end
      default: ;
    endcase
  end

  assign w_accept    = instr_valid & ~stall & (r_state != c_ST_HALTED);
  // The pc takes a target either when the delay slot retires or, without a
  // delay slot, directly on the taken transfer.
  assign w_redirect  = (r_state == c_ST_DELAY) | ((r_state == c_ST_RUN) & w_taken & ~c_DS);
  assign w_redir_tgt = (r_state == c_ST_DELAY) ? r_target : w_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_RUN;
      r_pc        <= RESET_VECTOR;
      r_target    <= 32'd0;
      r_link_we   <= 1'b0;
      r_link_reg  <= 5'd0;
      r_link_data <= 32'd0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_link_we <= 1'b0;
      if (w_accept) begin
        if ((r_state == c_ST_RUN) && w_link) begin
          r_link_we   <= 1'b1;
          r_link_reg  <= w_link_reg;
          r_link_data <= w_pc8;
        end
        if (w_redirect) begin
          if (w_redir_tgt[1:0] != 2'b00) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= c_ST_HALTED;
          end else if (w_redir_tgt == HALT_ADDR) begin
            r_pc     <= HALT_ADDR;
            r_halted <= 1'b1;
            r_state  <= c_ST_HALTED;
          end else begin
            r_pc    <= w_redir_tgt;
            r_state <= c_ST_RUN;
          end
        end else if (w_taken && c_DS) begin
          r_pc     <= w_pc4;
          r_target <= w_target;
          r_state  <= c_ST_DELAY;
        end else begin
          r_pc <= w_pc4;
        end
      end
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_taken_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired_cnt <= 32'd0;
      r_taken_cnt   <= 32'd0;
    end else if (w_accept) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
      if ((r_state == c_ST_RUN) && w_taken)
        r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign taken_cnt   = r_taken_cnt;
`endif

  assign pc        = r_pc;
  assign link_we   = r_link_we;
  assign link_reg  = r_link_reg;
  assign link_data = r_link_data;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mips_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_pc_sequencer
// Purpose  : Table-driven directed bench for mips_pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_data;
  logic        halted;
  logic        fault;
`ifdef PC_BRANCH_STATS_EN
  logic [31:0] retired_cnt;
  logic [31:0] taken_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  mips_pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .stall       (stall),
    .instr       (instr),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .pc          (pc),
    .link_we     (link_we),
    .link_reg    (link_reg),
    .link_data   (link_data),
    .halted      (halted),
`ifdef PC_BRANCH_STATS_EN
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt),
`endif
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        stl;
    logic [31:0] ins;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_halt;
    logic        e_fault;
  } vec_t;

  localparam int NV = 27;
  localparam logic [31:0] NOP = 32'h0000_0000;
  vec_t vec [NV];

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [31:0] i, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] p,
                              input logic we, input logic [4:0] rg,
                              input logic [31:0] d, input logic h, input logic f);
    vec_t t;
    t.rst = r; t.valid = v; t.stl = s; t.ins = i; t.rs = a; t.rt = b;
    t.e_pc = p; t.e_we = we; t.e_reg = rg; t.e_data = d; t.e_halt = h; t.e_fault = f;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
  endtask

  task automatic check_all(input int idx, input logic [31:0] e_pc, input logic e_we,
                           input logic [4:0] e_reg, input logic [31:0] e_data,
                           input logic e_halt, input logic e_fault);
    chk("pc",        idx, pc,               e_pc);
    chk("link_we",   idx, {31'd0, link_we}, {31'd0, e_we});
    chk("link_reg",  idx, {27'd0, link_reg},{27'd0, e_reg});
    chk("link_data", idx, link_data,        e_data);
    chk("halted",    idx, {31'd0, halted},  {31'd0, e_halt});
    chk("fault",     idx, {31'd0, fault},   {31'd0, e_fault});
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset = r; instr_valid = v; stall = s; instr = i; rs_val = a; rt_val = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // BEQ / BLTZAL / BNE+stall / J with JAL in slot / JAL / BLEZ / BGTZ / BGEZ / JR->0
    vec[0]  = mk(0,1,0,32'h10220004,5,5,          32'hBFC00004,0,0, 32'h0,0,0);
    vec[1]  = mk(0,1,0,NOP,0,0,                   32'hBFC00014,0,0, 32'h0,0,0);
    vec[2]  = mk(0,1,0,NOP,0,0,                   32'hBFC00018,0,0, 32'h0,0,0);
    vec[3]  = mk(0,1,0,32'h04300010,1,0,          32'hBFC0001C,1,31,32'hBFC00020,0,0);
    vec[4]  = mk(0,0,0,NOP,0,0,                   32'hBFC0001C,0,31,32'hBFC00020,0,0);
    vec[5]  = mk(0,1,0,32'h1422FFFE,1,2,          32'hBFC00020,0,31,32'hBFC00020,0,0);
    vec[6]  = mk(0,1,1,NOP,0,0,                   32'hBFC00020,0,31,32'hBFC00020,0,0);
    vec[7]  = mk(0,1,1,NOP,0,0,                   32'hBFC00020,0,31,32'hBFC00020,0,0);
    vec[8]  = mk(0,1,1,NOP,0,0,                   32'hBFC00020,0,31,32'hBFC00020,0,0);
    vec[9]  = mk(0,1,0,NOP,0,0,                   32'hBFC00018,0,31,32'hBFC00020,0,0);
    vec[10] = mk(0,1,0,32'h0BF00040,0,0,          32'hBFC0001C,0,31,32'hBFC00020,0,0);
    vec[11] = mk(0,1,0,32'h0C000000,0,0,          32'hBFC00100,0,31,32'hBFC00020,0,0);
    vec[12] = mk(0,1,0,32'h0FF00080,0,0,          32'hBFC00104,1,31,32'hBFC00108,0,0);
    vec[13] = mk(0,1,0,NOP,0,0,                   32'hBFC00200,0,31,32'hBFC00108,0,0);
    vec[14] = mk(0,1,0,32'h18200004,0,0,          32'hBFC00204,0,31,32'hBFC00108,0,0);
    vec[15] = mk(0,1,0,NOP,0,0,                   32'hBFC00214,0,31,32'hBFC00108,0,0);
    vec[16] = mk(0,1,0,32'h1C200004,32'h80000000,0,32'hBFC00218,0,31,32'hBFC00108,0,0);
    vec[17] = mk(0,1,0,32'h04210001,0,0,          32'hBFC0021C,0,31,32'hBFC00108,0,0);
    vec[18] = mk(0,1,0,NOP,0,0,                   32'hBFC00220,0,31,32'hBFC00108,0,0);
    vec[19] = mk(0,1,0,32'h00200008,0,0,          32'hBFC00224,0,31,32'hBFC00108,0,0);
    vec[20] = mk(0,1,0,NOP,0,0,                   32'h00000000,0,31,32'hBFC00108,1,0);
    vec[21] = mk(0,1,0,NOP,0,0,                   32'h00000000,0,31,32'hBFC00108,1,0);
    vec[22] = mk(0,1,0,32'h0C000000,0,0,          32'h00000000,0,31,32'hBFC00108,1,0);
    // reset, then JALR rd=5 to a misaligned target
    vec[23] = mk(1,0,0,NOP,0,0,                   32'hBFC00000,0,0, 32'h0,0,0);
    vec[24] = mk(0,1,0,32'h00202809,32'h00400002,0,32'hBFC00004,1,5,32'hBFC00008,0,0);
    vec[25] = mk(0,1,0,NOP,0,0,                   32'hBFC00004,0,5, 32'hBFC00008,1,1);
    vec[26] = mk(0,1,0,NOP,0,0,                   32'hBFC00004,0,5, 32'hBFC00008,1,1);

    reset = 1'b1; instr_valid = 1'b0; stall = 1'b0;
    instr = NOP; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 32'hBFC00000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(vec[i].rst, vec[i].valid, vec[i].stl, vec[i].ins, vec[i].rs, vec[i].rt);
      check_all(i, vec[i].e_pc, vec[i].e_we, vec[i].e_reg, vec[i].e_data,
                vec[i].e_halt, vec[i].e_fault);
    end

    // Reset while in the delay slot discards the pending target.
    step(1, 0, 0, NOP, 0, 0);
    step(0, 1, 0, 32'h10220004, 7, 7);
    chk("pre_reset_pc", 100, pc, 32'hBFC00004);
    step(1, 1, 0, NOP, 0, 0);
    chk("mid_delay_reset_pc", 101, pc, 32'hBFC00000);
    step(0, 1, 0, NOP, 0, 0);
    chk("post_reset_pc", 102, pc, 32'hBFC00004);
    chk("post_reset_halted", 103, {31'd0, halted}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
